// File: rtl/mem_byte_lsu_pkg.sv
// Shared encodings for the byte-serial memory-stage LSU: request sizes,
// FSM states and size helpers.
package mem_byte_lsu_pkg;

  typedef enum logic [1:0] {
    MEMCNF_NONE = 2'd0,
    MEMCNF_B    = 2'd1,
    MEMCNF_H    = 2'd2,
    MEMCNF_W    = 2'd3
  } memcnf_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_LAST = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  function automatic logic [2:0] cnf_nbytes(input logic [1:0] cnf);
    case (memcnf_e'(cnf))
      MEMCNF_B: return 3'd1;
      MEMCNF_H: return 3'd2;
      MEMCNF_W: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

  function automatic logic cnf_misaligned(input logic [1:0] cnf, input logic [1:0] a);
    case (memcnf_e'(cnf))
      MEMCNF_H: return a[0];
      MEMCNF_W: return |a;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_lsu_extend.sv
// lsu_extend: combinational sign/zero extension of an assembled
// little-endian load result according to the access size.
module lsu_extend
  import mem_byte_lsu_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  cnf_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  always_comb begin
    case (memcnf_e'(cnf_i))
      MEMCNF_B: data_o = {{24{signed_i & raw_i[7]}},  raw_i[7:0]};
      MEMCNF_H: data_o = {{16{signed_i & raw_i[15]}}, raw_i[15:0]};
      default:  data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_byte_lsu.sv
// Memory-stage LSU: serialises B/H/W requests onto an 8-bit RAM bus and
// stalls the pipe until done. Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W.
module mem_byte_lsu
  import mem_byte_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memaddr_i,
  input  logic        memwr_i,
  input  logic [1:0]  memcnf_i,
  input  logic        memsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        mem_stall_o,
  output logic        misalign_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [31:0] ram_addr_o,
  output logic        ram_wr_o,
  output logic [7:0]  ram_dout_o,
  input  logic [7:0]  ram_din_i
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  k_q, k_d, last_q, last_d, cnf_q, cnf_d, kp;
  logic [31:0] addr_q, addr_d, data_q, data_d, ext;
  logic        wr_q, wr_d, sgn_q, sgn_d, mis_q, mis_d;
  logic [2:0]  nb_m1;
  logic        misal;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal = cnf_misaligned(memcnf_i, memaddr_i[1:0]);
`else
  assign misal = 1'b0;
`endif

  assign nb_m1 = cnf_nbytes(memcnf_i) - 3'd1;
  assign kp    = k_q - 2'd1;

  lsu_extend u_ext (
    .raw_i   (data_q),
    .cnf_i   (cnf_q),
    .signed_i(sgn_q),
    .data_o  (ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      last_q  <= '0;
      cnf_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      last_q  <= last_d;
      cnf_q   <= cnf_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      sgn_q   <= sgn_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    last_d  = last_q;
    cnf_d   = cnf_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    sgn_d   = sgn_q;
    mis_d   = mis_q;
    wd_o        = wd_i;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    mem_stall_o = 1'b0;
    misalign_o  = 1'b0;
    bus_req_o   = 1'b0;
    ram_addr_o  = '0;
    ram_wr_o    = 1'b0;
    ram_dout_o  = '0;

    case (state_q)
      S_IDLE: begin
        if (memcnf_i == MEMCNF_NONE) begin
          wreg_o  = wreg_i;
          wdata_o = wdata_i;
        end else begin
          mem_stall_o = 1'b1;
          bus_req_o   = ~misal;
          // Misaligned trap requests skip arbitration entirely.
          if (misal || bus_gnt_i) begin
            addr_d  = memaddr_i;
            wr_d    = memwr_i;
            cnf_d   = memcnf_i;
            last_d  = nb_m1[1:0];
            sgn_d   = memsigned_i;
            data_d  = memwr_i ? wdata_i : 32'd0;
            k_d     = '0;
            mis_d   = misal;
            state_d = misal ? S_DONE : S_XFER;
          end
        end
      end
      S_XFER: begin
        mem_stall_o = 1'b1;
        bus_req_o   = 1'b1;
        ram_addr_o  = addr_q + {30'd0, k_q};
        if (wr_q) begin
          ram_wr_o   = 1'b1;
          ram_dout_o = data_q[{k_q, 3'b000} +: 8];
        end else if (k_q != 2'd0) begin
          // Read data lags its address by one cycle.
          data_d[{kp, 3'b000} +: 8] = ram_din_i;
        end
        if (k_q == last_q) state_d = wr_q ? S_DONE : S_LAST;
        else               k_d = k_q + 2'd1;
      end
      S_LAST: begin
        mem_stall_o = 1'b1;
        data_d[{last_q, 3'b000} +: 8] = ram_din_i;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (mis_q) begin
          misalign_o = 1'b1;
        end else if (!wr_q) begin
          wreg_o  = wreg_i;
          wdata_o = ext;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rst) begin
      wd_o        = '0;
      wreg_o      = 1'b0;
      wdata_o     = '0;
      mem_stall_o = 1'b0;
      misalign_o  = 1'b0;
      bus_req_o   = 1'b0;
      ram_addr_o  = '0;
      ram_wr_o    = 1'b0;
      ram_dout_o  = '0;
    end
  end

endmodule

// File: tb/tb_mem_byte_lsu.sv
// Directed bench for mem_byte_lsu with a byte-wide RAM model (read data one
// cycle after address); covers loads, stores, grant stalls, pass-through and reset.
module tb_mem_byte_lsu;

  logic        clk = 1'b0, rst;
  logic [31:0] memaddr_i, wdata_i, wdata_o, ram_addr_o;
  logic        memwr_i, memsigned_i, wreg_i, wreg_o, mem_stall_o, misalign_o;
  logic        bus_req_o, bus_gnt_i, ram_wr_o;
  logic [1:0]  memcnf_i;
  logic [4:0]  wd_i, wd_o;
  logic [7:0]  ram_dout_o, ram_din_i;

  logic [7:0]  mem [0:4095];
  logic [31:0] addr_log[$];
  logic [19:0] wr_log[$];
  int          n_chk = 0, n_fail = 0, pre_err, st;

  always #5 clk = ~clk;

  mem_byte_lsu dut (
    .clk(clk), .rst(rst), .memaddr_i(memaddr_i), .memwr_i(memwr_i),
    .memcnf_i(memcnf_i), .memsigned_i(memsigned_i), .wdata_i(wdata_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .mem_stall_o(mem_stall_o), .misalign_o(misalign_o),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .ram_addr_o(ram_addr_o),
    .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
  );

  always @(posedge clk) begin
    if (ram_wr_o) mem[ram_addr_o[11:0]] <= ram_dout_o;
    ram_din_i <= mem[ram_addr_o[11:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request and counts stall cycles until stall falls (DONE).
  task automatic access(input logic [1:0] cnf, input logic wr, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdat,
                        input int gdly, output int stalls);
    bit acc = 0;
    addr_log.delete(); wr_log.delete(); pre_err = 0; stalls = -1;
    memcnf_i = cnf; memwr_i = wr; memsigned_i = sgn; memaddr_i = addr; wdata_i = wdat;
    for (int c = 0; c < 40; c++) begin
      bus_gnt_i = (c >= gdly);
      #2;
      if (!mem_stall_o) begin stalls = c; break; end
      if (!bus_gnt_i && (!bus_req_o || ram_wr_o)) pre_err++;
      if (acc && bus_req_o) begin
        addr_log.push_back(ram_addr_o);
        if (ram_wr_o) wr_log.push_back({ram_addr_o[11:0], ram_dout_o});
      end
      if (bus_gnt_i) acc = 1;
      @(posedge clk); #1;
    end
  endtask

  task automatic retire;
    @(posedge clk); #1;
    memcnf_i = 2'd0; bus_gnt_i = 1'b0; wdata_i = '0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h78; mem[12'h101] = 8'h56; mem[12'h102] = 8'h34; mem[12'h103] = 8'h12;
    mem[12'h200] = 8'h80;
    mem[12'h210] = 8'h34; mem[12'h211] = 8'hF2;
    mem[12'h500] = 8'hEE;
    mem[12'hFFE] = 8'h11; mem[12'hFFF] = 8'h22; mem[12'h000] = 8'h33; mem[12'h001] = 8'h44;

    // Reset forces every output low even with a live request.
    rst = 1'b1; memcnf_i = 2'd1; memwr_i = 1'b1; memsigned_i = 1'b0; memaddr_i = 32'h10;
    wdata_i = 32'h55; wd_i = 5'd3; wreg_i = 1'b1; bus_gnt_i = 1'b1;
    @(posedge clk); #1; #2;
    chk("rst_stall", {31'd0, mem_stall_o}, 32'd0);
    chk("rst_req", {31'd0, bus_req_o}, 32'd0);
    chk("rst_wr", {31'd0, ram_wr_o}, 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_wd", {27'd0, wd_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; memcnf_i = 2'd0; bus_gnt_i = 1'b0; wd_i = 5'd9;

    // Non-memory pass-through.
    #2;
    chk("alu_wdata", wdata_o, 32'h55);
    chk("alu_wreg", {31'd0, wreg_o}, 32'd1);
    chk("alu_wd", {27'd0, wd_o}, 32'd9);
    chk("alu_stall", {31'd0, mem_stall_o}, 32'd0);
    chk("alu_misal", {31'd0, misalign_o}, 32'd0);
    @(posedge clk); #1;

    // LW 0x100
    wd_i = 5'd7;
    access(2'd3, 1'b0, 1'b0, 32'h100, 32'h0, 0, st);
    chk("lw_stalls", st, 32'd6);
    chk("lw_data", wdata_o, 32'h12345678);
    chk("lw_wreg", {31'd0, wreg_o}, 32'd1);
    chk("lw_wd", {27'd0, wd_o}, 32'd7);
    chk("lw_naddr", addr_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("lw_addr", addr_log[i], 32'h100 + i);
    retire();

    // LB / LBU / LH
    access(2'd1, 1'b0, 1'b1, 32'h200, 32'h0, 0, st);
    chk("lb_stalls", st, 32'd3);
    chk("lb_data", wdata_o, 32'hFFFFFF80);
    retire();
    access(2'd1, 1'b0, 1'b0, 32'h200, 32'h0, 0, st);
    chk("lbu_data", wdata_o, 32'h00000080);
    retire();
    access(2'd2, 1'b0, 1'b1, 32'h210, 32'h0, 0, st);
    chk("lh_stalls", st, 32'd4);
    chk("lh_data", wdata_o, 32'hFFFFF234);
    retire();

    // SH 0xABCD1234 to 0x300
    access(2'd2, 1'b1, 1'b0, 32'h300, 32'hABCD1234, 0, st);
    chk("sh_stalls", st, 32'd3);
    chk("sh_wreg", {31'd0, wreg_o}, 32'd0);
    chk("sh_wdata", wdata_o, 32'd0);
    chk("sh_nwr", wr_log.size(), 32'd2);
    if (wr_log.size() == 2) begin
      chk("sh_wr0", {12'd0, wr_log[0]}, {12'd0, 12'h300, 8'h34});
      chk("sh_wr1", {12'd0, wr_log[1]}, {12'd0, 12'h301, 8'h12});
    end
    retire();
    chk("sh_mem", {16'd0, mem[12'h301], mem[12'h300]}, 32'h1234);

    // SB with grant withheld 3 cycles
    access(2'd1, 1'b1, 1'b0, 32'h400, 32'h000000A5, 3, st);
    chk("sb_stalls", st, 32'd5);
    chk("sb_pregnt", pre_err, 32'd0);
    chk("sb_nwr", wr_log.size(), 32'd1);
    retire();
    chk("sb_mem", {24'd0, mem[12'h400]}, 32'hA5);

`ifndef LSU_MISALIGN_TRAP_EN
    // Misaligned LW crossing the top of the address space wraps to 0.
    access(2'd3, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h0, 0, st);
    chk("wrap_data", wdata_o, 32'h44332211);
    chk("wrap_misal", {31'd0, misalign_o}, 32'd0);
    chk("wrap_naddr", addr_log.size(), 32'd4);
    if (addr_log.size() == 4) begin
      chk("wrap_a1", addr_log[1], 32'hFFFFFFFF);
      chk("wrap_a2", addr_log[2], 32'h0);
    end
    retire();
`else
    access(2'd3, 1'b0, 1'b0, 32'h102, 32'h0, 10, st);
    chk("mis_stalls", st, 32'd1);
    chk("mis_flag", {31'd0, misalign_o}, 32'd1);
    chk("mis_wreg", {31'd0, wreg_o}, 32'd0);
    chk("mis_wdata", wdata_o, 32'd0);
    chk("mis_naddr", addr_log.size(), 32'd0);
    retire();
`endif

    // Reset on the 2nd cycle (first XFER) of an SW.
    memcnf_i = 2'd3; memwr_i = 1'b1; memaddr_i = 32'h500; wdata_i = 32'h01020304; bus_gnt_i = 1'b1;
    #2;
    chk("sw_idle_req", {31'd0, bus_req_o}, 32'd1);
    @(posedge clk); #1;
    #2;
    chk("sw_xfer_wr", {31'd0, ram_wr_o}, 32'd1);
    chk("sw_xfer_dout", {24'd0, ram_dout_o}, 32'h04);
    rst = 1'b1;
    #1;
    chk("sw_rst_wr", {31'd0, ram_wr_o}, 32'd0);
    chk("sw_rst_stall", {31'd0, mem_stall_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; memwr_i = 1'b0; memcnf_i = 2'd1; bus_gnt_i = 1'b0;
    #2;
    chk("post_rst_req", {31'd0, bus_req_o}, 32'd1);
    chk("post_rst_addr", ram_addr_o, 32'd0);
    chk("post_rst_wr", {31'd0, ram_wr_o}, 32'd0);
    chk("sw_abandon_mem", {24'd0, mem[12'h500]}, 32'hEE);
    memcnf_i = 2'd0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_byte_lsu.md
# mem_byte_lsu

Memory-stage load/store unit that sits between the EX stage's memory request outputs and the 8-bit single-port RAM bus. It turns one byte/halfword/word request (address, direction, size, signedness, store data) into a sequence of byte-wide RAM cycles. It assembles and extends load results little-endian and stalls the pipeline until the access completes. Non-memory instructions pass through with zero latency.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- memaddr_i  in  32  byte address of access
- memwr_i  in  1  0 = load, 1 = store
- memcnf_i  in  2  0 = no access, 1 = B, 2 = H, 3 = W
- memsigned_i  in  1  1 = sign-extend load, 0 = zero-extend (ignored for stores)
- wdata_i  in  32  ALU result (non-memory) or store data (store)
- wd_i  in  5  destination register
- wreg_i  in  1  destination write enable
- wd_o  out  5  destination register to MEM/WB
- wreg_o  out  1  write enable to MEM/WB
- wdata_o  out  32  writeback data
- mem_stall_o  out  1  hold EX/MEM and earlier stages
- misalign_o  out  1  misaligned-access flag (see Configuration)
- bus_req_o  out  1  RAM bus request to the arbiter
- bus_gnt_i  in  1  RAM bus grant
- ram_addr_o  out  32  RAM byte address
- ram_wr_o  out  1  RAM write strobe
- ram_dout_o  out  8  RAM write byte
- ram_din_i  in  8  RAM read byte; valid the cycle after its address is driven

## Operation
- States: IDLE, XFER, LAST, DONE.
- IDLE, memcnf_i = 0: wd_o/wreg_o/wdata_o = inputs, combinationally; stall low.
- IDLE, memcnf_i ≠ 0: the following hold:
  - bus_req_o = 1 and mem_stall_o = 1, both combinational.
  - If bus_gnt_i = 1 at the edge: capture addr, wr, N = 1/2/4 bytes, signed flag, wdata_i; set k = 0; go to XFER.
  - Otherwise stay in IDLE.
- XFER: drive ram_addr_o = base + k and bus_req_o = 1.
  - Store: ram_wr_o = 1, ram_dout_o = wdata byte k (byte 0 = bits 7:0).
  - Load: ram_wr_o = 0; capture ram_din_i into byte k−1 when k ≥ 1.
  - When k = N−1: store goes to DONE, load goes to LAST. Otherwise k increments.
- LAST (load only): capture ram_din_i into byte N−1; go to DONE; bus_req_o = 0.
- DONE: stall low.
  - Load: wdata_o = extended result. B: 24 copies of bit 7 (signed) or zeros. H: 16 copies of bit 15 or zeros. W: unchanged.
  - Store: wreg_o = 0 and wdata_o = 0.
  - wd_o = wd_i in both cases.
  - Next state is IDLE unconditionally. The pipeline advances on this edge, so the same request is not re-accepted.
- Outside XFER: ram_wr_o = 0, ram_addr_o = 0, ram_dout_o = 0.
- Address arithmetic is 32-bit modulo; 0xFFFFFFFF + 1 wraps to 0.
- The arbiter holds bus_gnt_i from acceptance until bus_req_o falls. The grant is sampled only in IDLE.

## Timing
- Reset (rst = 1 at an edge): state IDLE, k = 0, captured registers 0.
- While rst = 1, all outputs are forced to 0 combinationally, including ram_wr_o, so an interrupted store issues no further writes.
- Latency, with the request accepted at edge T (granted):
  - Load of N bytes: stall high from the first cycle in IDLE through LAST; DONE at cycle T+N+2; N+2 stall cycles.
  - Store of N bytes: DONE at cycle T+N+1.
- A withheld grant extends IDLE 1:1.
- rst mid-XFER: the next state is IDLE and the partial store is abandoned.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: an H request with addr[0] ≠ 0, or a W request with addr[1:0] ≠ 0, is handled as follows:
  - Accepted without a grant and without bus activity; goes IDLE→DONE.
  - In DONE: misalign_o = 1, wreg_o = 0, wdata_o = 0.
- LSU_MISALIGN_TRAP_EN undefined: misaligned accesses run byte-serially like aligned ones; misalign_o is tied to 0.

## Structure
- Shared package holds:
  - the MEMCNF encodings (NONE/B/H/W);
  - the state enum;
  - the size-to-byte-count mapping.
- Natural sub-module: lsu_extend, a combinational 32-bit assembly plus sign/zero extension by size.

## Test plan
- LW at 0x100, RAM bytes 0x78,0x56,0x34,0x12, grant held: 6 stall cycles, then wdata_o = 0x12345678, wreg_o = 1; ram_addr_o sequence 0x100..0x103.
- LB signed at 0x200 = 0x80 → 0xFFFFFF80; LBU at the same address → 0x00000080; LH signed with bytes 0x34,0xF2 → 0xFFFFF234.
- SH of 0xABCD1234 to 0x300: ram_wr_o high for 2 cycles with (0x300, 0x34) then (0x301, 0x12); DONE with wreg_o = 0; 3 stall cycles.
- Grant withheld 3 cycles for an SB: bus_req_o high and stall high throughout, no ram_wr_o until grant; DONE 2 cycles after grant.
- ADD result 0x55, memcnf_i = 0: wdata_o = 0x55 the same cycle, stall never rises; rst asserted on the 2nd cycle of an SW: ram_wr_o drops immediately and the unit is in IDLE after the edge.
- With LSU_MISALIGN_TRAP_EN, LW at 0x102: no RAM cycles, misalign_o = 1 in DONE, wreg_o = 0.
